// File: rtl/lifo_pkg.sv
// Shared definitions for the parameterised LIFO stack: default geometry and
// the per-cycle operation encoding produced by the control decoder.
package lifo_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_DEPTH = 8;

    typedef enum logic [2:0] {
        OP_NOP     = 3'd0,
        OP_PUSH    = 3'd1,
        OP_POP     = 3'd2,
        OP_REPLACE = 3'd3,
        OP_BYPASS  = 3'd4,
        OP_FLUSH   = 3'd5
    } op_e;

    typedef struct packed {
        op_e  op;
        logic overflow;
        logic underflow;
    } ctrl_t;

    // Flush dominates. A push+pop pair never raises an error: it either
    // swaps the top entry or passes the input straight through.
    function automatic ctrl_t decode_op(
        input logic flush,
        input logic push,
        input logic pop,
        input logic full,
        input logic empty
    );
        ctrl_t c;
        c.op        = OP_NOP;
        c.overflow  = 1'b0;
        c.underflow = 1'b0;
        if (flush) begin
            c.op = OP_FLUSH;
        end else if (push && pop) begin
            c.op = empty ? OP_BYPASS : OP_REPLACE;
        end else if (push) begin
            if (full) c.overflow = 1'b1;
            else      c.op       = OP_PUSH;
        end else if (pop) begin
            if (empty) c.underflow = 1'b1;
            else       c.op        = OP_POP;
        end
        return c;
    endfunction

endpackage

// File: rtl/lifo_ram.sv
// Stack storage: one synchronous write port, one asynchronous read port.
module lifo_ram
    import lifo_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // NOTE: no reset on the array; entries above count are never observed,
    // so a reset would only cost routing and block RAM inference.
    always_ff @(posedge clk) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/param_lifo_stack.sv
// Parameterised LIFO stack with registered pop data, push/pop replace and
// empty bypass, synchronous flush and sticky overflow/underflow flags.
module param_lifo_stack
    import lifo_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int DEPTH    = DEF_DEPTH,
    parameter int AF_LEVEL = DEPTH - 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       flush,
    input  logic                       clr_err,
    input  logic [WIDTH-1:0]           data_in,
    output logic [WIDTH-1:0]           data_out,
    output logic                       pop_valid,
    output logic [WIDTH-1:0]           top,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty,
    output logic                       almost_full,
    output logic                       overflow,
    output logic                       underflow
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = $clog2(DEPTH);
    localparam logic [CW-1:0] DEPTH_CNT = CW'(DEPTH);
    localparam logic [CW-1:0] AF_CNT    = CW'(AF_LEVEL);

    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] data_out_q, data_out_d;
    logic             pop_valid_q, pop_valid_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;

    logic             ram_we;
    logic [AW-1:0]    ram_waddr;
    logic [AW-1:0]    top_addr;
    logic [WIDTH-1:0] top_data;
    ctrl_t            ctrl;

    // Status flags come straight from the count register, no extra latency.
    assign empty       = (count_q == '0);
    assign full        = (count_q == DEPTH_CNT);
    assign almost_full = (count_q >= AF_CNT);
    assign top_addr    = empty ? '0 : AW'(count_q - CW'(1));

    assign ctrl = decode_op(flush, push, pop, full, empty);

    lifo_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk     (clk),
        .we_i    (ram_we),
        .waddr_i (ram_waddr),
        .wdata_i (data_in),
        .raddr_i (top_addr),
        .rdata_o (top_data)
    );

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // through the case statement can infer a latch.
        count_d     = count_q;
        data_out_d  = data_out_q;
        pop_valid_d = 1'b0;
        ram_we      = 1'b0;
        ram_waddr   = AW'(count_q);
        unique case (ctrl.op)
            OP_PUSH: begin
                ram_we  = 1'b1;
                count_d = count_q + CW'(1);
            end
            OP_POP: begin
                data_out_d  = top_data;
                pop_valid_d = 1'b1;
                count_d     = count_q - CW'(1);
            end
            OP_REPLACE: begin
                data_out_d  = top_data;
                pop_valid_d = 1'b1;
                ram_we      = 1'b1;
                ram_waddr   = top_addr;
            end
            OP_BYPASS: begin
                data_out_d  = data_in;
                pop_valid_d = 1'b1;
            end
            OP_FLUSH: begin
                count_d = '0;
            end
            default: ;
        endcase

        // A newly raised error outranks a same-cycle clear.
        overflow_d  = (overflow_q  & ~clr_err) | ctrl.overflow;
        underflow_d = (underflow_q & ~clr_err) | ctrl.underflow;
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q     <= '0;
            data_out_q  <= '0;
            pop_valid_q <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            count_q     <= count_d;
            data_out_q  <= data_out_d;
            pop_valid_q <= pop_valid_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign count     = count_q;
    assign data_out  = data_out_q;
    assign pop_valid = pop_valid_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;
    assign top       = empty ? '0 : top_data;

endmodule
